// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: register-file geometry
// and the supported latency ranges for the load and mul/div paths.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int REG_ZERO   = 0;

  localparam int LD_LAT_MIN = 1;
  localparam int LD_LAT_MAX = 3;
  localparam int MD_LAT_MIN = 2;
  localparam int MD_LAT_MAX = 32;

  // Out-of-range latency parameters are pulled into the supported window.
  function automatic int clampInt(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Down-counter tracking how long the multi-cycle multiply/divide unit stays
// occupied after an operation enters EX.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int LAT = clampInt(MD_LAT, MD_LAT_MIN, MD_LAT_MAX);
  localparam int CW  = $clog2(LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A new start always restarts the full latency, even when already busy.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside the ID stage: load-use and mul/div stalls, branch
// flushes, and a saturating stall-cycle counter for performance monitoring.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int LD_LAT = 1,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_ex,
  input  logic [REG_AW-1:0] RegWriteAddr_ex,
  input  logic [REG_AW-1:0] RsAddr_id,
  input  logic [REG_AW-1:0] RtAddr_id,
  input  logic              RsUsed_id,
  input  logic              RtUsed_id,
  input  logic              MdUse_id,
  input  logic              MdStart_ex,
  input  logic              BranchTaken_ex,
  output logic              stall,
  output logic              PC_IFWrite,
  output logic              IF_IDFlush,
  output logic              ID_EXFlush,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam int LD_LAT_C = clampInt(LD_LAT, LD_LAT_MIN, LD_LAT_MAX);
  localparam int PIPE_D   = LD_LAT_C - 1;
  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

  function automatic logic srcHit(input logic [REG_AW-1:0] dst,
                                  input logic rsLive, input logic [REG_AW-1:0] rs,
                                  input logic rtLive, input logic [REG_AW-1:0] rt);
    return (rsLive && rs == dst) || (rtLive && rt == dst);
  endfunction

  logic rsLive, rtLive, exMatch, pipeMatch, mdHazard;
  logic [CNT_W-1:0] stallCnt_q;

  // Register zero is hardwired, so a source of $0 can never depend on a load.
  assign rsLive  = RsUsed_id && (RsAddr_id != ZERO_ADDR);
  assign rtLive  = RtUsed_id && (RtAddr_id != ZERO_ADDR);
  assign exMatch = MemRead_ex && srcHit(RegWriteAddr_ex, rsLive, RsAddr_id, rtLive, RtAddr_id);

  if (PIPE_D > 0) begin : g_ldPipe
    logic [PIPE_D-1:0] vld_q;
    logic [REG_AW-1:0] addr_q [PIPE_D];

    // Free-running: loads keep moving toward writeback while ID is held.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= MemRead_ex;
        for (int k = 1; k < PIPE_D; k++) vld_q[k] <= vld_q[k-1];
      end
      addr_q[0] <= RegWriteAddr_ex;
      for (int k = 1; k < PIPE_D; k++) addr_q[k] <= addr_q[k-1];
    end

    always_comb begin
      pipeMatch = 1'b0;
      for (int k = 0; k < PIPE_D; k++) begin
        if (vld_q[k] && srcHit(addr_q[k], rsLive, RsAddr_id, rtLive, RtAddr_id)) pipeMatch = 1'b1;
      end
    end
  end else begin : g_noPipe
    assign pipeMatch = 1'b0;
  end

  md_busy_timer #(
    .MD_LAT(MD_LAT)
  ) u_mdTimer (
    .clk  (clk),
    .rst  (rst),
    .start(MdStart_ex),
    .busy (MdBusy)
  );

  assign mdHazard = MdUse_id && (MdBusy || MdStart_ex);

  // A taken branch squashes the stalled ID instruction, so it wins over any stall.
  assign stall      = (exMatch || pipeMatch || mdHazard) && !BranchTaken_ex && !rst;
  assign PC_IFWrite = !stall;
  assign IF_IDFlush = BranchTaken_ex && !rst;
  assign ID_EXFlush = (stall || BranchTaken_ex) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else if (stall && (stallCnt_q != '1)) begin
      stallCnt_q <= stallCnt_q + CNT_W'(1);
    end
  end

  assign StallCnt = stallCnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage MIPS core. It replaces the purely combinational load-use detector and sits beside the ID stage, driving the PC, IF/ID and ID/EX control. It handles:
- load-use stalls over a configurable load latency, with a register-zero exemption and per-operand use qualifiers;
- stalls behind a multi-cycle multiply/divide unit;
- flushes on a taken branch or jump.

It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- REG_AW, 5, register address width
- LD_LAT, 1, load-to-use distance in stages (1 = result forwardable from MEM; 2 = one further stage); range 1..3
- MD_LAT, 4, multiply/divide busy cycles after issue; range 2..32
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- MemRead_ex  in  1  EX-stage instruction is a load
- RegWriteAddr_ex  in  REG_AW  EX-stage destination register
- RsAddr_id  in  REG_AW  ID-stage rs
- RtAddr_id  in  REG_AW  ID-stage rt
- RsUsed_id  in  1  ID instruction reads rs
- RtUsed_id  in  1  ID instruction reads rt
- MdUse_id  in  1  ID instruction issues to or reads from the mul/div unit (mult, div, mfhi, mflo)
- MdStart_ex  in  1  mul/div operation enters EX this cycle
- BranchTaken_ex  in  1  taken branch or jump resolved in EX
- stall  out  1  insert bubble; hold PC and IF/ID
- PC_IFWrite  out  1  PC and IF/ID write enable (= ~stall)
- IF_IDFlush  out  1  clear IF/ID
- ID_EXFlush  out  1  clear ID/EX (bubble or branch squash)
- MdBusy  out  1  mul/div unit occupied
- StallCnt  out  CNT_W  cycles with stall=1 since reset, saturating

## Operation
- Load pipe: a LD_LAT-1 deep shift register of {valid, addr}.
  - Every cycle, entry 0 ← {MemRead_ex, RegWriteAddr_ex} and entry k ← entry k-1.
  - The pipe always advances; it is not gated by stall.
- A load match exists when a live source register equals either:
  - the EX load destination (MemRead_ex=1), or
  - any valid pipe entry.
- Live source: RsAddr_id with RsUsed_id=1, or RtAddr_id with RtUsed_id=1. An address of 0 never matches.
- Mul/div timer:
  - MdStart_ex loads the down-counter with MD_LAT.
  - MdBusy = (counter != 0); the counter decrements while nonzero.
  - MdStart_ex while busy reloads the counter to MD_LAT.
- md_hazard = MdUse_id & (MdBusy | MdStart_ex).
- Output equations:
  - stall = (load_match | md_hazard) & ~BranchTaken_ex & ~rst
  - PC_IFWrite = ~stall
  - IF_IDFlush = BranchTaken_ex & ~rst
  - ID_EXFlush = (stall | BranchTaken_ex) & ~rst
- Priority: a branch flush overrides any stall. The stalled ID instruction is on the wrong path and is squashed.
- StallCnt increments on each cycle with stall=1 and holds at all-ones.

## Timing
- All hazard outputs are combinational from the inputs and the current state, valid in the same cycle. There are no registered outputs except MdBusy and StallCnt.
- Load stall duration for a dependent instruction directly after the load is LD_LAT cycles.
- MdStart_ex at cycle t: MdBusy=1 for cycles t+1..t+MD_LAT. A dependent MdUse_id stalls in cycles t..t+MD_LAT.
- Reset (synchronous; asserted in cycle t, state values from t+1):
  - Load pipe valid bits are 0, the mul/div counter is 0, MdBusy=0 and StallCnt=0.
  - While rst=1, stall=0, PC_IFWrite=1, IF_IDFlush=0 and ID_EXFlush=0.
  - Reset mid-stall cancels the stall; the timer does not resume.
- Simultaneous MdStart_ex and rst: rst wins and the counter stays 0.
- Simultaneous load match and BranchTaken_ex: no stall; both flushes are asserted.

## Structure
- Package hazard_pkg holds:
  - REG_AW default and the REG_ZERO constant;
  - LD_LAT and MD_LAT range limits.
- Sub-module md_busy_timer (clk, rst, start, busy) holds the MD_LAT down-counter.
- The load pipe, match logic, priority and StallCnt stay in hazard_ctrl.

## Test plan
- LD_LAT=1, lw writing $5 in EX, ID add reading rs=$5 (RsUsed_id=1) -> stall=1, PC_IFWrite=0 and ID_EXFlush=1 for exactly 1 cycle; StallCnt=1.
- Same lw, but the ID instruction has rt=$5 with RtUsed_id=0 -> no stall. Load to $0 with rs=$0 -> no stall.
- LD_LAT=2, lw $7 then a dependent instruction directly behind it -> stall for 2 consecutive cycles. With one independent instruction between them -> stall 1 cycle.
- MD_LAT=4, MdStart_ex at cycle 10 and mflo held in ID -> stall in cycles 10..14, released in cycle 15; MdBusy high in cycles 11..14.
- Load match and BranchTaken_ex in the same cycle -> stall=0, IF_IDFlush=1, ID_EXFlush=1.
- CNT_W=4 with 20 forced stall cycles -> StallCnt saturates at 15. rst asserted mid mul/div -> next cycle MdBusy=0, StallCnt=0, no stall.
